cpu_clk_ctrl: RTL and testbench

//  Run/step/halt sequencer for the 8-bit CPU core clock enable, clocked by the 125 MHz board clock.

---
 rtl/cpu_clk_ctrl_if.sv | 25 ++
 rtl/cpu_clk_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board-level front panel and the CPU clock sequencer.
// The sequencer is the slave: it owns cpu_ce, clk_vis and the state debug field.
interface cpu_clk_ctrl_if #(
  parameter int CNT_W = 31
);
  logic             run_sw;
  logic             step_btn;
  logic             resume_btn;
  logic             cpu_halt;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             cpu_ce;
  logic             clk_vis;
  logic [1:0]       state;

  modport master (
    output run_sw, step_btn, resume_btn, cpu_halt, div_load, div_value,
    input  cpu_ce, clk_vis, state
  );

  modport slave (
    input  run_sw, step_btn, resume_btn, cpu_halt, div_load, div_value,
    output cpu_ce, clk_vis, state
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer producing single-cycle CPU clock enables on the one clk domain.
// Optional button debouncing is built when CLK_CTRL_DEBOUNCE_EN is defined.
module cpu_clk_ctrl #(
  parameter int CNT_W       = 31,
  parameter int DIV_DEFAULT = 62499999,
  parameter int DEB_CYCLES  = 1250000
) (
  input logic           clk,
  input logic           rst,
  cpu_clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_div;
  logic             r_ce;
  logic             w_ce_nxt;
  logic             r_vis;
  logic             w_tc;

  logic r_run_s1, r_run_s2;
  logic r_step_s1, r_step_s2;
  logic r_res_s1, r_res_s2;
  logic w_step_lvl, w_res_lvl;
  logic r_step_lvl_d, r_res_lvl_d;
  logic w_step_rise, w_res_rise;

  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("cpu_clk_ctrl: DEB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_res_s1  <= 1'b0;
      r_res_s2  <= 1'b0;
    end else begin
      r_run_s1  <= bus.run_sw;
      r_run_s2  <= r_run_s1;
      r_step_s1 <= bus.step_btn;
      r_step_s2 <= r_step_s1;
      r_res_s1  <= bus.resume_btn;
      r_res_s2  <= r_res_s1;
    end
  end

`ifdef CLK_CTRL_DEBOUNCE_EN
  // A level is accepted once it has differed from the current output for DEB_CYCLES edges in a row.
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             r_step_deb, r_res_deb;
  logic [DEB_W-1:0] r_step_dcnt, r_res_dcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_deb  <= 1'b0;
      r_step_dcnt <= '0;
      r_res_deb   <= 1'b0;
      r_res_dcnt  <= '0;
    end else begin
      if (r_step_s2 == r_step_deb) begin
        r_step_dcnt <= '0;
      end else if (r_step_dcnt == DEB_LAST) begin
        r_step_deb  <= r_step_s2;
        r_step_dcnt <= '0;
      end else begin
        r_step_dcnt <= r_step_dcnt + 1'b1;
      end
      if (r_res_s2 == r_res_deb) begin
        r_res_dcnt <= '0;
      end else if (r_res_dcnt == DEB_LAST) begin
        r_res_deb  <= r_res_s2;
        r_res_dcnt <= '0;
      end else begin
        r_res_dcnt <= r_res_dcnt + 1'b1;
      end
    end
  end

  assign w_step_lvl = r_step_deb;
  assign w_res_lvl  = r_res_deb;
`else
  assign w_step_lvl = r_step_s2;
  assign w_res_lvl  = r_res_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_lvl_d <= 1'b0;
      r_res_lvl_d  <= 1'b0;
    end else begin
      r_step_lvl_d <= w_step_lvl;
      r_res_lvl_d  <= w_res_lvl;
    end
  end

  assign w_step_rise = w_step_lvl & ~r_step_lvl_d;
  assign w_res_rise  = w_res_lvl & ~r_res_lvl_d;

  // >= rather than == so a divisor lowered below the running count fires at once instead of wrapping.
  assign w_tc = (r_count >= r_div);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ce_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_count_nxt = '0;
        if (r_run_s2) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_rise) begin
          w_state_nxt = ST_STEP;
          w_ce_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.cpu_halt) begin
          w_state_nxt = ST_HALTED;
          w_count_nxt = '0;
        end else if (!r_run_s2) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else if (w_tc) begin
          w_count_nxt = '0;
          w_ce_nxt    = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      ST_STEP: begin
        w_count_nxt = '0;
        w_state_nxt = bus.cpu_halt ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: begin
        w_count_nxt = '0;
        if (w_res_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // div_load is a single-cycle strobe with no back-pressure; div_value is taken on the edge it is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_div   <= CNT_W'(DIV_DEFAULT);
      r_ce    <= 1'b0;
      r_vis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ce    <= w_ce_nxt;
      if (w_ce_nxt) begin
        r_vis <= ~r_vis;
      end
      if (bus.div_load) begin
        r_div <= bus.div_value;
      end
    end
  end

  assign bus.cpu_ce  = r_ce;
  assign bus.clk_vis = r_vis;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: cycle model of the run/step/halt rules plus directed latency checks.
module tb_cpu_clk_ctrl;
  localparam int CNT_W = 31;
  localparam int DIV   = 9;
  localparam int DEB   = 4;
`ifdef CLK_CTRL_DEBOUNCE_EN
  localparam int BTN_LAT = DEB + 3;
`else
  localparam int BTN_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   ce_total = 0;

  cpu_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_clk_ctrl #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input histories, bit 0 = most recent sample; a synchronized level lags the pin by two edges.
  logic [7:0]       h_run, h_step, h_res;
  int               m_st, m_el;
  logic [CNT_W-1:0] m_div;
  logic             m_ce, m_vis;
  logic             m_sdeb, m_sdeb_old, m_rdeb, m_rdeb_old;
  logic [3:0]       exp_q[$];

`ifdef CLK_CTRL_DEBOUNCE_EN
  function automatic logic deb_next(input logic [7:0] h, input logic cur);
    if (&h[DEB:1]) return 1'b1;
    if (~|h[DEB:1]) return 1'b0;
    return cur;
  endfunction
`endif

  task automatic model_edge();
    logic run_s, srise, rrise;
    if (rst) begin
      h_run = '0; h_step = '0; h_res = '0;
      m_st = 0; m_el = 0; m_div = CNT_W'(DIV); m_ce = 1'b0; m_vis = 1'b0;
      m_sdeb = 1'b0; m_sdeb_old = 1'b0; m_rdeb = 1'b0; m_rdeb_old = 1'b0;
    end else begin
      run_s = h_run[1];
`ifdef CLK_CTRL_DEBOUNCE_EN
      srise = m_sdeb & ~m_sdeb_old;
      rrise = m_rdeb & ~m_rdeb_old;
      m_sdeb_old = m_sdeb; m_sdeb = deb_next(h_step, m_sdeb);
      m_rdeb_old = m_rdeb; m_rdeb = deb_next(h_res, m_rdeb);
`else
      srise = h_step[1] & ~h_step[2];
      rrise = h_res[1] & ~h_res[2];
`endif
      m_ce = 1'b0;
      case (m_st)
        0: if (run_s) m_st = 1;
           else if (srise) begin m_st = 2; m_ce = 1'b1; end
        1: if (bus.cpu_halt) begin m_st = 3; m_el = 0; end
           else if (!run_s) begin m_st = 0; m_el = 0; end
           else if (CNT_W'(m_el) >= m_div) begin m_el = 0; m_ce = 1'b1; end
           else m_el++;
        2: m_st = bus.cpu_halt ? 3 : 0;
        default: if (rrise) m_st = 0;
      endcase
      if (m_ce) m_vis = ~m_vis;
      if (bus.div_load) m_div = bus.div_value;
      h_run  = {h_run[6:0], bus.run_sw};
      h_step = {h_step[6:0], bus.step_btn};
      h_res  = {h_res[6:0], bus.resume_btn};
    end
    exp_q.push_back({m_st[1:0], m_vis, m_ce});
  endtask

  always @(posedge clk) model_edge();

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", bus.state, e[3:2]);
      chk("clk_vis", bus.clk_vis, e[1]);
      chk("cpu_ce", bus.cpu_ce, e[0]);
      if (bus.cpu_ce === 1'b1) ce_total++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ce(input int max, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.cpu_ce !== 1'b1 && n < max);
  endtask

  task automatic wait_state(input logic [1:0] st, input int max, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.state !== st && n < max);
  endtask

  task automatic count_ce(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin @(negedge clk); if (bus.cpu_ce === 1'b1) n++; end
  endtask

  initial begin
    int n, base;
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.resume_btn = 1'b0;
    bus.cpu_halt = 1'b0; bus.div_load = 1'b0; bus.div_value = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", bus.state, 2'b00);
    chk("reset_ce", bus.cpu_ce, 1'b0);
    chk("reset_vis", bus.clk_vis, 1'b0);
    rst = 1'b0;

    // free run at the default divisor
    @(negedge clk); bus.run_sw = 1'b1;
    wait_state(2'b01, 20, n);  chk("run_entry_lat", n, 3);
    wait_ce(40, n);            chk("run_first_pulse", n, 10);
    chk("vis_after_pulse1", bus.clk_vis, 1'b1);
    wait_ce(40, n);            chk("run_period", n, 10);
    chk("vis_after_pulse2", bus.clk_vis, 1'b0);
    bus.run_sw = 1'b0;
    count_ce(30, n);           chk("idle_no_pulse", n, 0);
    chk("idle_state", bus.state, 2'b00);

    // single steps
    bus.step_btn = 1'b1;
    wait_ce(20, n);            chk("step_lat", n, BTN_LAT);
    chk("step_state", bus.state, 2'b10);
    count_ce(20, n);           chk("step_held_single", n, 0);
    chk("step_back_idle", bus.state, 2'b00);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
    bus.step_btn = 1'b1;
    wait_ce(20, n);            chk("step2_lat", n, BTN_LAT);
    count_ce(8, n);            chk("step2_single", n, 0);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);

    // halt at terminal count, then resume with cpu_halt still high
    bus.run_sw = 1'b1;
    wait_state(2'b01, 20, n);
    wait_ce(40, n);            chk("halt_pre_pulse", n, 10);
    repeat (9) @(negedge clk);
    bus.cpu_halt = 1'b1;
    @(negedge clk);
    chk("halt_no_ce", bus.cpu_ce, 1'b0);
    chk("halt_state", bus.state, 2'b11);
    bus.run_sw = 1'b0;
    count_ce(6, n);            chk("halted_no_pulse", n, 0);
    chk("halted_stays", bus.state, 2'b11);
    bus.resume_btn = 1'b1;
    repeat (BTN_LAT) @(negedge clk);
    chk("resume_state", bus.state, 2'b00);
    bus.resume_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_retrap", bus.state, 2'b00);
    bus.cpu_halt = 1'b0;

    // divisor reload mid-period, then divisor 0
    bus.run_sw = 1'b1;
    wait_state(2'b01, 20, n);
    repeat (7) @(negedge clk);
    bus.div_value = CNT_W'(3); bus.div_load = 1'b1;
    @(negedge clk); bus.div_load = 1'b0;
    wait_ce(20, n);            chk("div_low_fire", n, 1);
    wait_ce(20, n);            chk("div3_period_a", n, 4);
    wait_ce(20, n);            chk("div3_period_b", n, 4);
    bus.div_value = '0; bus.div_load = 1'b1;
    @(negedge clk); bus.div_load = 1'b0;
    @(negedge clk);
    count_ce(10, n);           chk("div0_continuous", n, 10);
    bus.run_sw = 1'b0;
    repeat (5) @(negedge clk);

    // reset during STEP and during RUN
    bus.step_btn = 1'b1;
    wait_state(2'b10, 20, n);  chk("step_entry_lat", n, BTN_LAT);
    rst = 1'b1; bus.step_btn = 1'b0;
    @(negedge clk);
    chk("rst_step_state", bus.state, 2'b00);
    chk("rst_step_ce", bus.cpu_ce, 1'b0);
    chk("rst_step_vis", bus.clk_vis, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    bus.run_sw = 1'b1;
    wait_state(2'b01, 20, n);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_run_state", bus.state, 2'b00);
    chk("rst_run_ce", bus.cpu_ce, 1'b0);
    chk("rst_run_vis", bus.clk_vis, 1'b0);
    rst = 1'b0;
    wait_state(2'b01, 20, n);  chk("rerun_entry_lat", n, 3);
    wait_ce(40, n);            chk("div_restored", n, 10);
    bus.run_sw = 1'b0;
    repeat (10) @(negedge clk);

`ifdef CLK_CTRL_DEBOUNCE_EN
    // short bounces must not step; a stable press steps once
    base = ce_total;
    repeat (4) begin
      bus.step_btn = 1'b1; repeat (3) @(negedge clk);
      bus.step_btn = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("glitch_no_step", ce_total - base, 0);
    bus.step_btn = 1'b1;
    wait_ce(30, n);            chk("deb_step_lat", n, DEB + 3);
    bus.step_btn = 1'b0;
    repeat (12) @(negedge clk);
`else
    base = ce_total;
`endif
    chk("model_drained", exp_q.size() <= 1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
